// File: rtl/egr_dpb_pfs_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : egr_dpb_pfs_stall_ctrl
// Brief    : Per-channel PFS stall generator. Each channel has an occupancy
//            counter with watermark hysteresis. A global occupancy limit and a
//            software force-stall can also stall any channel.
// Revision : 1.0 - initial release
// ============================================================================
module egr_dpb_pfs_stall_ctrl #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int TOT_W  = CNT_W + $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       inc_v,
    input  logic [NUM_CH-1:0]       dec_v,
    input  logic [CNT_W-1:0]        cfg_hi_wm,
    input  logic [CNT_W-1:0]        cfg_lo_wm,
    input  logic [TOT_W-1:0]        cfg_glb_wm,
    input  logic [NUM_CH-1:0]       cfg_force_stall,
    input  logic                    err_clr,
    output logic [NUM_CH-1:0]       stall,
    output logic                    glb_stall,
    output logic [NUM_CH*CNT_W-1:0] occ,
    output logic [NUM_CH-1:0]       err_ovf,
    output logic [NUM_CH-1:0]       err_udf
);

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [0:0]       c_st_run   = 1'b0;
    localparam logic [0:0]       c_st_stall = 1'b1;

    logic [NUM_CH-1:0][CNT_W-1:0] w_cnt_nxt_all;
    logic [NUM_CH-1:0]            w_fsm_stall;
    logic [TOT_W-1:0]             w_tot_nxt;
    logic                         r_glb_stall;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [0:0]       r_state;
        logic [0:0]       w_state_nxt;
        logic             w_ovf_set;
        logic             w_udf_set;
        logic             r_ovf;
        logic             r_udf;

        // Simultaneous inc and dec cancel out and never flag an error.
        always_comb begin
            w_cnt_nxt = r_cnt;
            w_ovf_set = 1'b0;
            w_udf_set = 1'b0;
            case ({inc_v[i], dec_v[i]})
                2'b10: begin
                    if (r_cnt == c_cnt_max) w_ovf_set = 1'b1;
                    else                    w_cnt_nxt = r_cnt + 1'b1;
                end
                2'b01: begin
                    if (r_cnt == '0) w_udf_set = 1'b1;
                    else             w_cnt_nxt = r_cnt - 1'b1;
                end
                default: ;
            endcase
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                c_st_run:   if (w_cnt_nxt >= cfg_hi_wm) w_state_nxt = c_st_stall;
                c_st_stall: if (w_cnt_nxt <= cfg_lo_wm) w_state_nxt = c_st_run;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt   <= '0;
                r_state <= c_st_run;
                r_ovf   <= 1'b0;
                r_udf   <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_state <= w_state_nxt;
                // A new error event wins over a same-cycle clear.
                if (w_ovf_set)    r_ovf <= 1'b1;
                else if (err_clr) r_ovf <= 1'b0;
                if (w_udf_set)    r_udf <= 1'b1;
                else if (err_clr) r_udf <= 1'b0;
            end
        end

        assign w_cnt_nxt_all[i]         = w_cnt_nxt;
        assign w_fsm_stall[i]           = (r_state == c_st_stall);
        assign occ[i*CNT_W +: CNT_W]    = r_cnt;
        assign err_ovf[i]               = r_ovf;
        assign err_udf[i]               = r_udf;
    end

    always_comb begin
        w_tot_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_tot_nxt = w_tot_nxt + TOT_W'(w_cnt_nxt_all[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_glb_stall <= 1'b0;
        else     r_glb_stall <= (w_tot_nxt >= cfg_glb_wm);
    end

    assign glb_stall = r_glb_stall;
    assign stall     = w_fsm_stall | cfg_force_stall | {NUM_CH{r_glb_stall}};

endmodule
`default_nettype wire

// File: tb/tb_egr_dpb_pfs_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_egr_dpb_pfs_stall_ctrl
// Brief    : Directed bench with a behavioural model feeding a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_egr_dpb_pfs_stall_ctrl;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int TOT_W  = CNT_W + $clog2(NUM_CH);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       inc_v, dec_v, cfg_force_stall;
    logic [CNT_W-1:0]        cfg_hi_wm, cfg_lo_wm;
    logic [TOT_W-1:0]        cfg_glb_wm;
    logic                    err_clr;
    logic [NUM_CH-1:0]       stall, err_ovf, err_udf;
    logic                    glb_stall;
    logic [NUM_CH*CNT_W-1:0] occ;

    egr_dpb_pfs_stall_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk(clk), .rst(rst), .inc_v(inc_v), .dec_v(dec_v),
        .cfg_hi_wm(cfg_hi_wm), .cfg_lo_wm(cfg_lo_wm), .cfg_glb_wm(cfg_glb_wm),
        .cfg_force_stall(cfg_force_stall), .err_clr(err_clr),
        .stall(stall), .glb_stall(glb_stall), .occ(occ),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  stall;
        logic        glb;
        logic [31:0] occ;
        logic [3:0]  ovf;
        logic [3:0]  udf;
    } exp_t;

    exp_t sb[$];
    int   m_cnt[NUM_CH];
    bit   m_st[NUM_CH], m_ovf[NUM_CH], m_udf[NUM_CH];
    bit   m_glb;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < NUM_CH; i++) begin
            e.stall[i]          = m_st[i] | cfg_force_stall[i] | m_glb;
            e.occ[i*8 +: 8]     = 8'(m_cnt[i]);
            e.ovf[i]            = m_ovf[i];
            e.udf[i]            = m_udf[i];
        end
        e.glb = m_glb;
        return e;
    endfunction

    task automatic model_step(input logic [3:0] inc, input logic [3:0] dec,
                              input bit r, input bit clr);
        int tot;
        tot = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            int n;
            bit ov, ud;
            if (r) begin
                m_cnt[i] = 0; m_st[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
                continue;
            end
            n = m_cnt[i]; ov = 0; ud = 0;
            if (inc[i] && !dec[i]) begin
                if (n == 255) ov = 1; else n = n + 1;
            end else if (dec[i] && !inc[i]) begin
                if (n == 0) ud = 1; else n = n - 1;
            end
            m_ovf[i] = ov ? 1'b1 : (clr ? 1'b0 : m_ovf[i]);
            m_udf[i] = ud ? 1'b1 : (clr ? 1'b0 : m_udf[i]);
            if (!m_st[i]) begin
                if (n >= int'(cfg_hi_wm)) m_st[i] = 1;
            end else if (n <= int'(cfg_lo_wm)) begin
                m_st[i] = 0;
            end
            m_cnt[i] = n;
            tot += n;
        end
        m_glb = r ? 1'b0 : (tot >= int'(cfg_glb_wm));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        chk({tag, "_stall"}, 32'(stall), 32'(e.stall));
        chk({tag, "_glb"},   32'(glb_stall), 32'(e.glb));
        chk({tag, "_occ"},   occ, e.occ);
        chk({tag, "_ovf"},   32'(err_ovf), 32'(e.ovf));
        chk({tag, "_udf"},   32'(err_udf), 32'(e.udf));
    endtask

    // One clock: drive, predict, push; after the edge pop and compare.
    task automatic cycle(input string tag, input logic [3:0] inc, input logic [3:0] dec,
                         input bit r, input bit clr);
        exp_t e;
        rst = r; inc_v = inc; dec_v = dec; err_clr = clr;
        model_step(inc, dec, r, clr);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_assert++; n_fail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            cmp_all(tag, e);
        end
    endtask

    initial begin
        rst = 1'b1; inc_v = '0; dec_v = '0; err_clr = 1'b0; cfg_force_stall = '0;
        cfg_hi_wm = 8'd10; cfg_lo_wm = 8'd4; cfg_glb_wm = 10'd255;
        @(negedge clk);

        // Reset then idle
        repeat (3) cycle("reset", 4'h0, 4'h0, 1'b1, 1'b0);
        repeat (2) cycle("idle", 4'h0, 4'h0, 1'b0, 1'b0);
        chk("idle_occ", occ, 32'h0);
        chk("idle_stall", 32'(stall), 32'h0);

        // Hysteresis on ch0
        for (int k = 1; k <= 10; k++) begin
            cycle("hyst_inc", 4'h1, 4'h0, 1'b0, 1'b0);
            chk("hyst_rise", 32'(stall[0]), (k == 10) ? 32'd1 : 32'd0);
        end
        chk("hyst_occ10", 32'(occ[7:0]), 32'd10);
        for (int k = 9; k >= 4; k--) begin
            cycle("hyst_dec", 4'h0, 4'h1, 1'b0, 1'b0);
            chk("hyst_fall", 32'(stall[0]), (k > 4) ? 32'd1 : 32'd0);
        end
        chk("hyst_others", 32'(stall[3:1]), 32'h0);
        repeat (4) cycle("hyst_drain", 4'h0, 4'h1, 1'b0, 1'b0);

        // Simultaneous inc/dec on ch1 at cnt=10
        repeat (10) cycle("sim_fill", 4'h2, 4'h0, 1'b0, 1'b0);
        repeat (20) cycle("sim_both", 4'h2, 4'h2, 1'b0, 1'b0);
        chk("sim_occ1", 32'(occ[15:8]), 32'd10);
        chk("sim_stall1", 32'(stall[1]), 32'd1);
        chk("sim_err", 32'({err_ovf, err_udf}), 32'h0);
        repeat (10) cycle("sim_drain", 4'h0, 4'h2, 1'b0, 1'b0);

        // Global limit
        cfg_glb_wm = 10'd20; cfg_hi_wm = 8'd200;
        for (int k = 1; k <= 5; k++) begin
            cycle("glb_inc", 4'hF, 4'h0, 1'b0, 1'b0);
            chk("glb_rise", 32'(glb_stall), (k == 5) ? 32'd1 : 32'd0);
        end
        chk("glb_all_stall", 32'(stall), 32'hF);
        cycle("glb_dec", 4'h0, 4'h1, 1'b0, 1'b0);
        chk("glb_fall", 32'(glb_stall), 32'd0);
        chk("glb_fall_stall", 32'(stall), 32'h0);
        repeat (5) cycle("glb_drain", 4'h0, 4'hF, 1'b0, 1'b0);

        // Saturation and underflow (ch0 dec at zero above also flags udf[0])
        cycle("clr0", 4'h0, 4'h0, 1'b0, 1'b1);
        cfg_glb_wm = 10'd1023;
        repeat (256) cycle("sat_inc", 4'h4, 4'h0, 1'b0, 1'b0);
        cycle("sat_extra", 4'h4, 4'h0, 1'b0, 1'b0);
        chk("sat_occ2", 32'(occ[23:16]), 32'd255);
        chk("sat_ovf2", 32'(err_ovf[2]), 32'd1);
        cycle("udf_dec", 4'h0, 4'h8, 1'b0, 1'b0);
        chk("udf_occ3", 32'(occ[31:24]), 32'd0);
        chk("udf_flag3", 32'(err_udf[3]), 32'd1);
        cycle("set_vs_clr", 4'h4, 4'h0, 1'b0, 1'b1);
        chk("set_wins", 32'(err_ovf[2]), 32'd1);
        cycle("err_clr", 4'h0, 4'h0, 1'b0, 1'b1);
        chk("err_cleared", 32'({err_ovf, err_udf}), 32'h0);

        // Force stall is combinational
        cycle("pre_reset", 4'h0, 4'h0, 1'b1, 1'b0);
        cfg_hi_wm = 8'd10; cfg_glb_wm = 10'd255;
        cfg_force_stall = 4'b1000;
        #1;
        chk("force_same", 32'(stall), 32'h8);
        cycle("force_hold", 4'h0, 4'h0, 1'b0, 1'b0);
        cfg_force_stall = 4'b0000;
        #1;
        chk("force_off", 32'(stall), 32'h0);

        // Reset mid-operation with ch0 stalled at 12; traffic during rst is ignored
        repeat (12) cycle("mid_inc", 4'h1, 4'h0, 1'b0, 1'b0);
        chk("mid_stall0", 32'(stall[0]), 32'd1);
        cycle("mid_rst", 4'hF, 4'h0, 1'b1, 1'b0);
        chk("mid_occ0", 32'(occ[7:0]), 32'd0);
        chk("mid_stall0_clr", 32'(stall[0]), 32'd0);
        cycle("post_rst", 4'h0, 4'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
